icache_lookup: RTL

ICACHE_LOOKUP -- requirements
Module: icache_lookup

---
 rtl/icache_lookup.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/icache_lookup.sv
// Two-way set-associative instruction-cache tag lookup driven by a trace command stream.
// Each fetch reports a hit or a miss and updates the LRU state. The clear command invalidates the whole array one set per cycle.
module icache_lookup #(
  parameter int ADDR_W      = 32,
  parameter int SET_BITS    = 4,
  parameter int OFFSET_BITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        n,
  input  logic [ADDR_W-1:0] addr,
  output logic              n_valid,
  output logic [3:0]        n_out,
  output logic              i_hit,
  output logic              i_miss
);

  localparam int TAG_W = ADDR_W - SET_BITS - OFFSET_BITS;
  localparam int SETS  = 1 << SET_BITS;
  localparam logic [3:0] CMD_FETCH = 4'd2;
  localparam logic [3:0] CMD_CLEAR = 4'd8;

  typedef enum logic [1:0] {IDLE, LOOKUP, CLEAR, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          req_n_q, req_n_d;
  logic [SET_BITS-1:0] req_set_q, req_set_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [SET_BITS-1:0] sweep_q, sweep_d;
  logic                hit_q, hit_d;
  logic                way_q, way_d;
  logic                n_valid_q, n_valid_d;
  logic                i_hit_q, i_hit_d;
  logic                i_miss_q, i_miss_d;
  logic [3:0]          n_out_q, n_out_d;
  logic [1:0]          valid_q [SETS];
  logic [1:0]          valid_d [SETS];
  logic [SETS-1:0]     lru_q, lru_d;
  logic [TAG_W-1:0]    tag_mem_q [SETS][2];
  logic                tag_we;
  logic [1:0]          way_match;
  logic                is_fetch;
  logic                offset_unused;

  assign offset_unused = ^addr[OFFSET_BITS-1:0];
  assign is_fetch      = (req_n_q == CMD_FETCH);
  assign cmd_ready     = (state_q == IDLE);

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      way_match[w] = valid_q[req_set_q][w] && (tag_mem_q[req_set_q][w] == req_tag_q);
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    req_n_d   = req_n_q;
    req_set_d = req_set_q;
    req_tag_d = req_tag_q;
    sweep_d   = sweep_q;
    hit_d     = hit_q;
    way_d     = way_q;
    n_out_d   = n_out_q;
    n_valid_d = 1'b0;
    i_hit_d   = 1'b0;
    i_miss_d  = 1'b0;
    valid_d   = valid_q;
    lru_d     = lru_q;
    tag_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          req_n_d   = n;
          req_set_d = addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
          req_tag_d = addr[ADDR_W-1:OFFSET_BITS+SET_BITS];
          sweep_d   = '0;
          state_d   = (n == CMD_CLEAR) ? CLEAR : LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = |way_match;
        // The victim is chosen now so the fill at RESP only has to write.
        if (|way_match)                   way_d = way_match[1];
        else if (!valid_q[req_set_q][0])  way_d = 1'b0;
        else if (!valid_q[req_set_q][1])  way_d = 1'b1;
        else                              way_d = lru_q[req_set_q];
        n_valid_d = 1'b1;
        n_out_d   = req_n_q;
        i_hit_d   = is_fetch && (|way_match);
        i_miss_d  = is_fetch && !(|way_match);
        state_d   = RESP;
      end
      CLEAR: begin
        valid_d[sweep_q] = 2'b00;
        lru_d[sweep_q]   = 1'b0;
        if (&sweep_q) begin
          n_valid_d = 1'b1;
          n_out_d   = req_n_q;
          state_d   = RESP;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      RESP: begin
        if (is_fetch) begin
          lru_d[req_set_q] = ~way_q;
          if (!hit_q) begin
            valid_d[req_set_q][way_q] = 1'b1;
            tag_we = 1'b1;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_n_q   <= '0;
      req_set_q <= '0;
      req_tag_q <= '0;
      sweep_q   <= '0;
      hit_q     <= 1'b0;
      way_q     <= 1'b0;
      n_valid_q <= 1'b0;
      i_hit_q   <= 1'b0;
      i_miss_q  <= 1'b0;
      n_out_q   <= '0;
      valid_q   <= '{default: 2'b00};
      lru_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_n_q   <= req_n_d;
      req_set_q <= req_set_d;
      req_tag_q <= req_tag_d;
      sweep_q   <= sweep_d;
      hit_q     <= hit_d;
      way_q     <= way_d;
      n_valid_q <= n_valid_d;
      i_hit_q   <= i_hit_d;
      i_miss_q  <= i_miss_d;
      n_out_q   <= n_out_d;
      valid_q   <= valid_d;
      lru_q     <= lru_d;
    end
  end

  // NOTE: tag storage is not reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem_q[req_set_q][way_q] <= req_tag_q;
  end

  // The strobes are masked by rst so that a command aborted in its RESP cycle never retires.
  assign n_valid = n_valid_q & ~rst;
  assign i_hit   = i_hit_q   & ~rst;
  assign i_miss  = i_miss_q  & ~rst;
  assign n_out   = n_out_q;

endmodule
